axi_burst_mem_slave: RTL and testbench



---
 rtl/axi_burst_mem_slave_if.sv | 60 ++++++
 rtl/axi_burst_mem_slave.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 read/write channel bundle between a burst master and axi_burst_mem_slave.
interface axi_burst_mem_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;

    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WLAST, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WLAST, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst slave (FIXED/INCR/WRAP) in front of a single-port synchronous memory,
// with round-robin arbitration between the read and write address channels.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | pick a winning address channel, pulse its READY, capture it
// ST_WR_DATA | accept W beats, write each one straight through to memory
// ST_WR_RESP | hold B response until BREADY
// ST_RD_MEM  | issue one memory read for the current beat
// ST_RD_DATA | register mem_rdata, hold R beat until RREADY
module axi_burst_mem_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1024
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    axi_burst_mem_slave_if.slave     bus,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int NB     = DATA_WIDTH / 8;
    localparam int WS     = $clog2(NB);
    localparam int MEM_AW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_DATA = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_MEM  = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;

    logic [2:0]            state;
    logic                  wr_pri;
    logic                  awready_q;
    logic                  arready_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  burst_err_q;
    logic [8:0]            beat_q;
    logic                  wr_err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  rlast_q;
    logic                  rvalid_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]            sel_len;
    logic [2:0]            sel_size;
    logic [1:0]            sel_burst;
    logic [ADDR_WIDTH-1:0] sel_align_mask;
    logic                  cap_err;

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  oor;
    logic                  beat_last;
    logic                  beat_err;
    logic                  w_hs;
    logic                  wlast_bad;

    // The pending READY pulse tells which channel is being captured this cycle.
    assign sel_addr       = awready_q ? bus.AWADDR  : bus.ARADDR;
    assign sel_len        = awready_q ? bus.AWLEN   : bus.ARLEN;
    assign sel_size       = awready_q ? bus.AWSIZE  : bus.ARSIZE;
    assign sel_burst      = awready_q ? bus.AWBURST : bus.ARBURST;
    assign sel_align_mask = (ADDR_WIDTH'(1) << sel_size) - ADDR_WIDTH'(1);

    always_comb begin
        cap_err = 1'b0;
        if (sel_size > 3'(WS))
            cap_err = 1'b1;
        if (sel_burst == 2'b11)
            cap_err = 1'b1;
        if (sel_burst == 2'b10) begin
            if (!(sel_len == 8'd1 || sel_len == 8'd3 || sel_len == 8'd7 || sel_len == 8'd15))
                cap_err = 1'b1;
            if ((sel_addr & sel_align_mask) != '0)
                cap_err = 1'b1;
        end
    end

    assign step      = ADDR_WIDTH'(1) << size_q;
    assign incr_addr = addr_q + step;
    assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);

    always_comb begin
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
    end

    assign word_idx  = addr_q >> WS;
    assign oor       = word_idx >= DEPTH_W;
    assign beat_last = (beat_q == {1'b0, len_q});
    assign beat_err  = burst_err_q | oor;
    assign w_hs      = (state == ST_WR_DATA) && bus.WVALID;
    assign wlast_bad = bus.WLAST != beat_last;

    assign bus.AWREADY = awready_q;
    assign bus.ARREADY = arready_q;
    assign bus.WREADY  = (state == ST_WR_DATA);
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RLAST   = rlast_q;
    assign bus.RVALID  = rvalid_q;

    // Writes go to memory in the same cycle as the W handshake.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_hs && !beat_err) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = word_idx[MEM_AW-1:0];
            mem_wdata = bus.WDATA;
        end else if (state == ST_RD_MEM && !beat_err) begin
            mem_en   = 1'b1;
            mem_addr = word_idx[MEM_AW-1:0];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= ST_IDLE;
            wr_pri      <= 1'b1;
            awready_q   <= 1'b0;
            arready_q   <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            burst_err_q <= 1'b0;
            beat_q      <= '0;
            wr_err_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            rlast_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (awready_q || arready_q) begin
                        awready_q <= 1'b0;
                        arready_q <= 1'b0;
                        if ((awready_q && bus.AWVALID) || (arready_q && bus.ARVALID)) begin
                            addr_q      <= sel_addr;
                            len_q       <= sel_len;
                            size_q      <= sel_size;
                            burst_q     <= sel_burst;
                            burst_err_q <= cap_err;
                            beat_q      <= '0;
                            wr_err_q    <= 1'b0;
                            state       <= awready_q ? ST_WR_DATA : ST_RD_MEM;
                        end
                    end else if (bus.AWVALID && bus.ARVALID) begin
                        if (wr_pri)
                            awready_q <= 1'b1;
                        else
                            arready_q <= 1'b1;
                        wr_pri <= !wr_pri;
                    end else if (bus.AWVALID) begin
                        awready_q <= 1'b1;
                    end else if (bus.ARVALID) begin
                        arready_q <= 1'b1;
                    end
                end

                ST_WR_DATA: begin
                    if (bus.WVALID) begin
                        beat_q <= beat_q + 9'd1;
                        addr_q <= next_addr;
                        if (wlast_bad || oor)
                            wr_err_q <= 1'b1;
                        // Burst length is governed by AWLEN, not by WLAST.
                        if (beat_last) begin
                            state    <= ST_WR_RESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (wr_err_q || burst_err_q || oor || wlast_bad) ? 2'b10 : 2'b00;
                        end
                    end
                end

                ST_WR_RESP: begin
                    if (bus.BREADY) begin
                        bvalid_q <= 1'b0;
                        bresp_q  <= 2'b00;
                        state    <= ST_IDLE;
                    end
                end

                ST_RD_MEM: begin
                    state <= ST_RD_DATA;
                end

                ST_RD_DATA: begin
                    if (!rvalid_q) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= beat_err ? '0 : mem_rdata;
                        rresp_q  <= beat_err ? 2'b10 : 2'b00;
                        rlast_q  <= beat_last;
                    end else if (bus.RREADY) begin
                        rvalid_q <= 1'b0;
                        rdata_q  <= '0;
                        rresp_q  <= 2'b00;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            state <= ST_IDLE;
                        end else begin
                            beat_q <= beat_q + 9'd1;
                            addr_q <= next_addr;
                            state  <= ST_RD_MEM;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Scoreboard bench for axi_burst_mem_slave: expected memory accesses, R beats and
// B responses are queued as stimulus is issued and checked as the DUT emits them.
module tb_axi_burst_mem_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    axi_burst_mem_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    axi_burst_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          we;
        int          addr;
        logic [31:0] data;
    } mem_ev_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        bit          last;
    } r_ev_t;

    mem_ev_t    exp_mem[$];
    r_ev_t      exp_r[$];
    logic [1:0] exp_b[$];

    logic [31:0] ram   [0:1023];
    logic [31:0] model [0:1023];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int aw_cyc = 0;
    int ar_cyc = 0;

    mem_ev_t    mon_m;
    r_ev_t      mon_r;
    logic [1:0] mon_b;

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(posedge ACLK) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge ACLK) begin
        if (mem_en === 1'b1) begin
            if (exp_mem.size() > 0) begin
                mon_m = exp_mem.pop_front();
                chk("mem_we", 64'(mem_we), 64'(mon_m.we));
                chk("mem_addr", 64'(mem_addr), 64'(mon_m.addr));
                if (mon_m.we)
                    chk("mem_wdata", 64'(mem_wdata), 64'(mon_m.data));
            end else begin
                chk("mem_unexpected", 64'(mem_en), 64'd0);
            end
        end
        if (bus.RVALID === 1'b1 && bus.RREADY === 1'b1) begin
            if (exp_r.size() > 0) begin
                mon_r = exp_r.pop_front();
                chk("rdata", 64'(bus.RDATA), 64'(mon_r.data));
                chk("rresp", 64'(bus.RRESP), 64'(mon_r.resp));
                chk("rlast", 64'(bus.RLAST), 64'(mon_r.last));
            end else begin
                chk("r_unexpected", 64'(bus.RVALID), 64'd0);
            end
        end
        if (bus.BVALID === 1'b1 && bus.BREADY === 1'b1) begin
            if (exp_b.size() > 0) begin
                mon_b = exp_b.pop_front();
                chk("bresp", 64'(bus.BRESP), 64'(mon_b));
            end else begin
                chk("b_unexpected", 64'(bus.BVALID), 64'd0);
            end
        end
    end

    function automatic bit burst_bad(int start, int len, int size, int burst);
        if (size > 2) return 1'b1;
        if (burst == 3) return 1'b1;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        if (burst == 2 && (start % (1 << size)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int beat_addr(int start, int len, int size, int burst, int i);
        int step, wb, lower;
        step = 1 << size;
        case (burst)
            0: return start;
            2: begin
                wb    = (len + 1) * step;
                lower = (start / wb) * wb;
                return lower + ((start - lower) + i * step) % wb;
            end
            default: return start + i * step;
        endcase
    endfunction

    function automatic logic [31:0] beat_data(logic [31:0] seed, int i);
        return seed + 32'(i) * 32'h0101_0101;
    endfunction

    function automatic bit wlast_of(int i, int len, int early);
        return (early >= 0) ? (i == early) : (i == len);
    endfunction

    task automatic push_write(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                              input logic [1:0] b, input logic [31:0] seed, input int early);
        int il, w;
        bit berr, err;
        mem_ev_t m;
        il   = int'(l);
        berr = burst_bad(int'(a), il, int'(s), int'(b));
        err  = berr;
        for (int i = 0; i <= il; i++) begin
            w = beat_addr(int'(a), il, int'(s), int'(b), i) / 4;
            if (wlast_of(i, il, early) != (i == il)) err = 1'b1;
            if (w >= 1024) begin
                err = 1'b1;
            end else if (!berr) begin
                m.we   = 1'b1;
                m.addr = w;
                m.data = beat_data(seed, i);
                exp_mem.push_back(m);
                model[w] = m.data;
            end
        end
        exp_b.push_back(err ? 2'b10 : 2'b00);
    endtask

    task automatic push_read(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b);
        int il, w;
        bit berr;
        mem_ev_t m;
        r_ev_t r;
        il   = int'(l);
        berr = burst_bad(int'(a), il, int'(s), int'(b));
        for (int i = 0; i <= il; i++) begin
            w = beat_addr(int'(a), il, int'(s), int'(b), i) / 4;
            r.last = (i == il);
            if (berr || w >= 1024) begin
                r.data = 32'h0;
                r.resp = 2'b10;
            end else begin
                m.we   = 1'b0;
                m.addr = w;
                m.data = 32'h0;
                exp_mem.push_back(m);
                r.data = model[w];
                r.resp = 2'b00;
            end
            exp_r.push_back(r);
        end
    endtask

    function automatic logic sig_of(int which);
        case (which)
            0: return bus.AWREADY;
            1: return bus.ARREADY;
            2: return bus.WREADY;
            3: return bus.BVALID;
            4: return bus.RVALID;
            default: return bus.RVALID & bus.RREADY & bus.RLAST;
        endcase
    endfunction

    // Returns on the negedge where the chosen condition is seen, or after a cycle budget.
    task automatic wait_neg(input int which, input string tag);
        int n;
        n = 0;
        @(negedge ACLK);
        while (sig_of(which) !== 1'b1 && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        if (sig_of(which) !== 1'b1)
            chk(tag, 64'(sig_of(which)), 64'd1);
    endtask

    task automatic drive_write(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                               input logic [1:0] b, input logic [31:0] seed, input int early);
        bus.AWADDR  = a;
        bus.AWLEN   = l;
        bus.AWSIZE  = s;
        bus.AWBURST = b;
        bus.AWVALID = 1'b1;
        wait_neg(0, "aw_timeout");
        aw_cyc = cyc;
        @(posedge ACLK);
        #1;
        bus.AWVALID = 1'b0;
        chk("aw_pulse", 64'(bus.AWREADY), 64'd0);
        for (int i = 0; i <= int'(l); i++) begin
            bus.WDATA  = beat_data(seed, i);
            bus.WLAST  = wlast_of(i, int'(l), early);
            bus.WVALID = 1'b1;
            wait_neg(2, "w_timeout");
            @(posedge ACLK);
            #1;
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        wait_neg(3, "b_timeout");
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_read(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                              input logic [1:0] b, input bit wait_done);
        bus.ARADDR  = a;
        bus.ARLEN   = l;
        bus.ARSIZE  = s;
        bus.ARBURST = b;
        bus.ARVALID = 1'b1;
        wait_neg(1, "ar_timeout");
        ar_cyc = cyc;
        @(posedge ACLK);
        #1;
        bus.ARVALID = 1'b0;
        if (wait_done) begin
            wait_neg(5, "rlast_timeout");
            @(posedge ACLK);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]   = 32'h0;
            model[i] = 32'h0;
        end
        bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
        bus.WDATA  = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
        bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b1;

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", 64'(bus.AWREADY), 64'd0);
        chk("rst_arready", 64'(bus.ARREADY), 64'd0);
        chk("rst_wready",  64'(bus.WREADY),  64'd0);
        chk("rst_bvalid",  64'(bus.BVALID),  64'd0);
        chk("rst_rvalid",  64'(bus.RVALID),  64'd0);
        chk("rst_rdata",   64'(bus.RDATA),   64'd0);
        chk("rst_rlast",   64'(bus.RLAST),   64'd0);
        chk("rst_mem_en",  64'(mem_en),      64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;

        // single write, then fill words 5..7 and read 4..7 back
        push_write(16'h0010, 8'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, -1);
        drive_write(16'h0010, 8'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, -1);
        push_write(16'h0014, 8'd2, 3'd2, 2'b01, 32'h1111_0000, -1);
        drive_write(16'h0014, 8'd2, 3'd2, 2'b01, 32'h1111_0000, -1);
        push_read(16'h0010, 8'd3, 3'd2, 2'b01);
        drive_read(16'h0010, 8'd3, 3'd2, 2'b01, 1'b1);

        // wrap read 6,7,4,5 then illegal wrap length
        push_read(16'h0018, 8'd3, 3'd2, 2'b10);
        drive_read(16'h0018, 8'd3, 3'd2, 2'b10, 1'b1);
        push_read(16'h0018, 8'd2, 3'd2, 2'b10);
        drive_read(16'h0018, 8'd2, 3'd2, 2'b10, 1'b1);

        // top of memory: second beat out of range
        push_write(16'h0FFC, 8'd1, 3'd2, 2'b01, 32'hA5A5_0001, -1);
        drive_write(16'h0FFC, 8'd1, 3'd2, 2'b01, 32'hA5A5_0001, -1);
        push_read(16'h0FFC, 8'd1, 3'd2, 2'b01);
        drive_read(16'h0FFC, 8'd1, 3'd2, 2'b01, 1'b1);

        // fixed burst with early WLAST
        push_write(16'h0020, 8'd2, 3'd2, 2'b00, 32'h7000_0000, 1);
        drive_write(16'h0020, 8'd2, 3'd2, 2'b00, 32'h7000_0000, 1);

        // narrow stepping, oversize beat, reserved burst type
        push_read(16'h0021, 8'd3, 3'd0, 2'b01);
        drive_read(16'h0021, 8'd3, 3'd0, 2'b01, 1'b1);
        push_read(16'h0020, 8'd1, 3'd3, 2'b01);
        drive_read(16'h0020, 8'd1, 3'd3, 2'b01, 1'b1);
        push_write(16'h0050, 8'd1, 3'd2, 2'b11, 32'h3333_0000, -1);
        drive_write(16'h0050, 8'd1, 3'd2, 2'b11, 32'h3333_0000, -1);

        // simultaneous request: write wins first after reset
        push_write(16'h0080, 8'd1, 3'd2, 2'b01, 32'h1234_0000, -1);
        push_read(16'h0080, 8'd1, 3'd2, 2'b01);
        fork
            drive_write(16'h0080, 8'd1, 3'd2, 2'b01, 32'h1234_0000, -1);
            drive_read(16'h0080, 8'd1, 3'd2, 2'b01, 1'b1);
        join
        chk("arb1_write_first", 64'(aw_cyc < ar_cyc), 64'd1);

        // stalled R channel, then reset in the middle of the burst
        bus.RREADY = 1'b0;
        push_read(16'h0010, 8'd3, 3'd2, 2'b01);
        drive_read(16'h0010, 8'd3, 3'd2, 2'b01, 1'b0);
        wait_neg(4, "stall_rvalid_timeout");
        for (int k = 0; k < 5; k++) begin
            chk("stall_rvalid", 64'(bus.RVALID), 64'd1);
            chk("stall_rdata",  64'(bus.RDATA),  64'(exp_r[0].data));
            @(negedge ACLK);
        end
        @(posedge ACLK);
        #1;
        bus.RREADY = 1'b1;
        @(posedge ACLK);
        #1;
        bus.RREADY = 1'b0;
        wait_neg(4, "beat1_rvalid_timeout");
        #2;
        ARESETn = 1'b0;
        #1;
        chk("midrst_rvalid", 64'(bus.RVALID), 64'd0);
        chk("midrst_state",  64'(dut.state),  64'd0);
        chk("midrst_mem_en", 64'(mem_en),     64'd0);
        exp_mem.delete();
        exp_r.delete();
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;
        bus.RREADY = 1'b1;
        @(posedge ACLK);
        #1;

        // arbitration pointer restarts on write, then alternates to read
        push_write(16'h0040, 8'd0, 3'd2, 2'b01, 32'h55AA_0000, -1);
        push_read(16'h0040, 8'd0, 3'd2, 2'b01);
        fork
            drive_write(16'h0040, 8'd0, 3'd2, 2'b01, 32'h55AA_0000, -1);
            drive_read(16'h0040, 8'd0, 3'd2, 2'b01, 1'b1);
        join
        chk("arb2_write_first", 64'(aw_cyc < ar_cyc), 64'd1);

        push_read(16'h0014, 8'd0, 3'd2, 2'b01);
        push_write(16'h0030, 8'd1, 3'd2, 2'b01, 32'hCAFE_0000, -1);
        fork
            drive_write(16'h0030, 8'd1, 3'd2, 2'b01, 32'hCAFE_0000, -1);
            drive_read(16'h0014, 8'd0, 3'd2, 2'b01, 1'b1);
        join
        chk("arb3_read_first", 64'(ar_cyc < aw_cyc), 64'd1);

        repeat (4) @(posedge ACLK);
        #1;
        chk("mem_left", 64'(exp_mem.size()), 64'd0);
        chk("r_left",   64'(exp_r.size()),   64'd0);
        chk("b_left",   64'(exp_b.size()),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
